serial_target_responder: RTL and testbench

- Synchronous responder for the shared one-bit serial bus: it decodes a start bit and an address/command byte on RX, then either accepts a write byte or returns a read byte on TX.
- TX is driven to 0 whenever the block does not own the bus, so several instances can share the wired-OR MISO return line.
- A local parallel side lets the host logic preload read data and collect write data.

---
 rtl/serial_target_responder_if.sv | 14 +
 rtl/serial_target_responder.sv | 126 ++++++++++++
 tb/tb_serial_target_responder.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/serial_target_responder_if.sv
// Bus and host-side signal bundle for one serial target responder.
// The slave modport is the responder's view; master is the initiator/host view.
interface serial_target_responder_if;
    logic       rx;
    logic       tx;
    logic [7:0] data_in;
    logic       load;
    logic [7:0] data_out;
    logic       wr_valid;
    logic       busy;

    modport slave  (input  rx, data_in, load, output tx, data_out, wr_valid, busy);
    modport master (output rx, data_in, load, input  tx, data_out, wr_valid, busy);
endinterface

// File: rtl/serial_target_responder.sv
// One-bit serial bus target: decodes start + address/command, then accepts a write
// byte or returns a read byte; TX stays 0 unless this instance owns the return line.
module serial_target_responder #(
    parameter logic [6:0] DEV_ADDR   = 7'h0D,
    parameter logic [7:0] RESET_DATA = 8'h00
) (
    input  logic                        clk,
    input  logic                        rst_n,
    serial_target_responder_if.slave    bus
);
    typedef enum logic [2:0] {IDLE, ADDR, ACK, WDATA, RDATA, SKIP} state_t;

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic [7:0] rx_sr, rx_sr_nxt;
    logic [7:0] tx_sr, tx_sr_nxt;
    logic [7:0] data_reg, data_nxt;
    logic       rw, rw_nxt;
    logic       tx, tx_nxt;
    logic       wr_valid, wr_nxt;
    logic       busy, busy_nxt;
    logic [7:0] rx_byte;

    assign rx_byte = {rx_sr[6:0], bus.rx};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            rx_sr    <= 8'h00;
            tx_sr    <= 8'h00;
            data_reg <= RESET_DATA;
            rw       <= 1'b0;
            tx       <= 1'b0;
            wr_valid <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            rx_sr    <= rx_sr_nxt;
            tx_sr    <= tx_sr_nxt;
            data_reg <= data_nxt;
            rw       <= rw_nxt;
            tx       <= tx_nxt;
            wr_valid <= wr_nxt;
            busy     <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rx_sr_nxt = rx_sr;
        tx_sr_nxt = tx_sr;
        rw_nxt    = rw;
        tx_nxt    = 1'b0;
        wr_nxt    = 1'b0;
        // Host preload applies in any state; a completing bus write below overrides it.
        data_nxt  = bus.load ? bus.data_in : data_reg;
        case (state)
            IDLE: begin
                if (bus.rx) begin
                    state_nxt = ADDR;
                    cnt_nxt   = 4'd7;
                    rx_sr_nxt = 8'h00;
                end
            end
            ADDR: begin
                rx_sr_nxt = rx_byte;
                if (cnt == 4'd0) begin
                    if (rx_byte[7:1] == DEV_ADDR) begin
                        state_nxt = ACK;
                        tx_nxt    = 1'b1;
                        rw_nxt    = rx_byte[0];
                    end else begin
                        // Ride out the foreign frame so its data bits never look like a start.
                        state_nxt = SKIP;
                        cnt_nxt   = 4'd8;
                    end
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            ACK: begin
                cnt_nxt = 4'd7;
                if (rw) begin
                    tx_nxt    = data_reg[7];
                    tx_sr_nxt = {data_reg[6:0], 1'b0};
                    state_nxt = RDATA;
                end else begin
                    state_nxt = WDATA;
                end
            end
            RDATA: begin
                if (cnt == 4'd0) begin
                    state_nxt = IDLE;
                end else begin
                    tx_nxt    = tx_sr[7];
                    tx_sr_nxt = {tx_sr[6:0], 1'b0};
                    cnt_nxt   = cnt - 4'd1;
                end
            end
            WDATA: begin
                rx_sr_nxt = rx_byte;
                if (cnt == 4'd0) begin
                    data_nxt  = rx_byte;
                    wr_nxt    = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            SKIP: begin
                if (cnt == 4'd0) state_nxt = IDLE;
                else             cnt_nxt   = cnt - 4'd1;
            end
            default: state_nxt = IDLE;
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    assign bus.tx       = tx;
    assign bus.wr_valid = wr_valid;
    assign bus.busy     = busy;
    assign bus.data_out = data_reg;
endmodule

// File: tb/tb_serial_target_responder.sv
// Four responders on a shared RX / wired-OR TX bus; per-cycle expectations from a
// frame-level model are queued by the driver and checked by an independent monitor.
module tb_serial_target_responder;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b0;
    logic       load0 = 1'b0;
    logic [7:0] din0 = 8'h00;
    logic       tx_or;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic       tx;
        logic       wr;
        logic       busy;
        logic [7:0] data;
    } exp_t;
    exp_t exp_q[$];

    logic [6:0] maddr [4] = '{7'h0D, 7'h16, 7'h20, 7'h33};
    logic [7:0] rdata [4] = '{8'h00, 8'h3F, 8'h41, 8'h6C};
    logic [7:0] mdata [4];

    serial_target_responder_if b0();
    serial_target_responder_if b1();
    serial_target_responder_if b2();
    serial_target_responder_if b3();

    assign b0.rx = rx;  assign b0.load = load0; assign b0.data_in = din0;
    assign b1.rx = rx;  assign b1.load = 1'b0;  assign b1.data_in = 8'h00;
    assign b2.rx = rx;  assign b2.load = 1'b0;  assign b2.data_in = 8'h00;
    assign b3.rx = rx;  assign b3.load = 1'b0;  assign b3.data_in = 8'h00;
    assign tx_or = b0.tx | b1.tx | b2.tx | b3.tx;

    serial_target_responder #(.DEV_ADDR(7'h0D), .RESET_DATA(8'h00)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
    serial_target_responder #(.DEV_ADDR(7'h16), .RESET_DATA(8'h3F)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
    serial_target_responder #(.DEV_ADDR(7'h20), .RESET_DATA(8'h41)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));
    serial_target_responder #(.DEV_ADDR(7'h33), .RESET_DATA(8'h6C)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3.slave));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // Monitor: compares every cycle for which the driver queued an expectation.
    always @(posedge clk) begin
        exp_t e, a;
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '{tx: tx_or, wr: b0.wr_valid, busy: b0.busy, data: b0.data_out};
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL cycle @%0t: got tx=%b wr=%b busy=%b data=%h expected tx=%b wr=%b busy=%b data=%h",
                         $time, a.tx, a.wr, a.busy, a.data, e.tx, e.wr, e.busy, e.data);
            end
        end
    end

    task automatic idle(input bit do_load, input logic [7:0] lv);
        @(negedge clk);
        rx = 1'b0; load0 = do_load; din0 = lv;
        if (do_load) mdata[0] = lv;
        exp_q.push_back('{tx: 1'b0, wr: 1'b0, busy: 1'b0, data: mdata[0]});
    endtask

    // One full 18-cycle frame: c0 start, c1..c8 address, c9 ack, c10..c17 data.
    task automatic frame(input logic [7:0] ab, input logic [7:0] wd, input int load_at, input logic [7:0] lv);
        int m = -1;
        bit rd = ab[0];
        logic [7:0] snap = 8'h00;
        logic txe;
        for (int i = 0; i < 4; i++) if (maddr[i] == ab[7:1]) m = i;
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            if (k == 0)       rx = 1'b1;
            else if (k <= 8)  rx = ab[8-k];
            else if (k == 9)  rx = 1'($urandom);
            else if (rd)      rx = 1'($urandom);
            else              rx = wd[17-k];
            load0 = (k == load_at);
            din0  = lv;
            if (k == 9 && rd && m >= 0) snap = mdata[m];
            txe = 1'b0;
            if (k == 8) txe = (m >= 0);
            else if (k >= 9 && k <= 16 && rd && m >= 0) txe = snap[16-k];
            if (k == load_at) mdata[0] = lv;
            if (k == 17 && !rd && m >= 0) mdata[m] = wd;
            exp_q.push_back('{tx: txe, wr: (k == 17 && !rd && m == 0), busy: (k != 17), data: mdata[0]});
        end
    endtask

    initial begin
        logic [7:0] wbyte;
        for (int i = 0; i < 4; i++) mdata[i] = rdata[i];
        #1;
        check("reset_tx",   32'(tx_or),       32'(0));
        check("reset_busy", 32'(b0.busy),     32'(0));
        check("reset_wr",   32'(b0.wr_valid), 32'(0));
        check("reset_data", 32'(b0.data_out), 32'(8'h00));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        idle(1'b1, 8'h5D);                   // read of preloaded byte
        frame(8'h1B, 8'h00, -1, 8'h00);
        idle(1'b0, 8'h00);
        frame(8'h1A, 8'h3F, -1, 8'h00);      // write then read back
        frame(8'h1B, 8'h00, -1, 8'h00);
        frame(8'h2B, 8'hFF, -1, 8'h00);      // foreign frame, then back-to-back read
        frame(8'h1B, 8'h00, -1, 8'h00);
        frame({7'h16, 1'b1}, 8'h00, -1, 8'h00);
        frame({7'h20, 1'b1}, 8'h00, -1, 8'h00);
        frame({7'h33, 1'b1}, 8'h00, -1, 8'h00);
        frame(8'h1B, 8'h00, -1, 8'h00);
        idle(1'b1, 8'h5D);                   // LOAD mid-read leaves the snapshot alone
        frame(8'h1B, 8'h00, 12, 8'hAA);
        frame(8'h1B, 8'h00, -1, 8'h00);
        frame(8'h1A, 8'h77, 17, 8'h11);      // bus write beats a coincident LOAD
        frame(8'h1B, 8'h00, -1, 8'h00);

        for (int n = 0; n < 40; n++) begin
            int sel = $urandom_range(0, 4);
            int la  = -1;
            logic [7:0] ab = 8'($urandom);
            if (sel < 4) ab = {maddr[sel], 1'($urandom)};
            if ($urandom_range(0, 1) == 1) begin
                la = $urandom_range(1, 16);
                if (la >= 9) la++;
            end
            frame(ab, 8'($urandom), la, 8'($urandom));
            repeat ($urandom_range(0, 2)) idle(1'b0, 8'h00);
        end

        // Reset at c13 of a write of 8'h3F.
        idle(1'b0, 8'h00);
        wbyte = 8'h3F;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            load0 = 1'b0;
            if (k == 0)      rx = 1'b1;
            else if (k <= 8) rx = 8'h1A >> (8 - k);
            else if (k == 9) rx = 1'b0;
            else             rx = wbyte[17-k];
        end
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_tx",   32'(tx_or),       32'(0));
        check("midrst_busy", 32'(b0.busy),     32'(0));
        check("midrst_data", 32'(b0.data_out), 32'(8'h00));
        for (int k = 14; k < 18; k++) begin
            @(negedge clk);
            rx = wbyte[17-k];
            @(posedge clk);
            #1 check("midrst_wr", 32'(b0.wr_valid), 32'(0));
        end
        @(negedge clk);
        rx = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) mdata[i] = rdata[i];
        frame(8'h1B, 8'h00, -1, 8'h00);
        frame(8'h1A, 8'hA5, -1, 8'h00);
        frame(8'h1B, 8'h00, -1, 8'h00);
        idle(1'b0, 8'h00);

        repeat (3) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
